// File: rtl/mem_line_fetch.sv
// rtl/mem_line_fetch.sv - line-fill bridge: fetches one cache line as single-word beats
// from a narrower external read bus and returns it with a one-cycle done pulse.
module mem_line_fetch #(
    parameter int AddrBusWidth = 32,
    parameter int MemBusWidth  = 64,
    parameter int ExtBusWidth  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_avail,
    input  logic [AddrBusWidth-1:0] mem_addr,
    output logic                    mem_busy,
    output logic                    mem_done,
    output logic [MemBusWidth-1:0]  mem_data,
    output logic                    ext_req,
    output logic [AddrBusWidth-1:0] ext_addr,
    input  logic                    ext_gnt,
    input  logic                    ext_rvalid,
    input  logic [ExtBusWidth-1:0]  ext_rdata
);
    localparam int Beats     = MemBusWidth / ExtBusWidth;
    localparam int LineBytes = MemBusWidth / 8;
    localparam int BeatBytes = ExtBusWidth / 8;
    localparam int BeatW     = (Beats > 1) ? $clog2(Beats) : 1;
    localparam logic [AddrBusWidth-1:0] LineMask = AddrBusWidth'(LineBytes - 1);
    localparam logic [BeatW-1:0]        LastBeat = BeatW'(Beats - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [BeatW-1:0]        beat_q, beat_d;
    logic [AddrBusWidth-1:0] base_q, base_d;
    logic [MemBusWidth-1:0]  line_q, line_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            base_q  <= base_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        line_d  = line_q;
        unique case (state_q)
            IDLE: begin
                // Misaligned requests fetch the aligned line that contains them.
                if (mem_avail) begin
                    base_d  = mem_addr & ~LineMask;
                    beat_d  = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (ext_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ext_rvalid) begin
                    line_d[int'(beat_q) * ExtBusWidth +: ExtBusWidth] = ext_rdata;
                    if (beat_q == LastBeat) begin
                        state_d = DONE;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only, so there is no input-to-output path.
    assign mem_busy = (state_q != IDLE);
    assign mem_done = (state_q == DONE);
    assign mem_data = line_q;
    assign ext_req  = (state_q == ISSUE);
    assign ext_addr = base_q + AddrBusWidth'(beat_q) * AddrBusWidth'(BeatBytes);

endmodule

// File: tb/tb_mem_line_fetch.sv
// tb/tb_mem_line_fetch.sv - randomized scoreboard bench for mem_line_fetch,
// one instance with a 32-bit and one with a 16-bit external bus sharing the request side.
module tb_mem_line_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_avail;
    logic [31:0] mem_addr;
    int          cyc   = 0;
    int          tests = 0;
    int          fails = 0;
    bit          use_fixed;
    bit          stall_en;
    logic [31:0] fixed_base;
    logic [63:0] fixed_line;
    int          dir_gd [4];
    int          dir_rd [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input int g, input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL u%0d.%s at cycle %0d: got %h, expected %h", g, nm, cyc, act, exp);
        end
    endfunction

    // Byte-addressed external memory contents.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        if (use_fixed && a[31:3] == fixed_base[31:3]) return fixed_line[{a[2:0], 3'b000} +: 8];
        h = a * 32'h9E37_79B1;
        return h[23:16] ^ a[7:0];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int EW    = (g == 0) ? 32 : 16;
        localparam int BEATS = 64 / EW;
        localparam int BB    = EW / 8;

        logic          mem_busy;
        logic          mem_done;
        logic [63:0]   mem_data;
        logic          ext_req;
        logic [31:0]   ext_addr;
        logic          ext_gnt    = 1'b0;
        logic          ext_rvalid = 1'b0;
        logic [EW-1:0] ext_rdata  = '0;

        mem_line_fetch #(
            .AddrBusWidth(32),
            .MemBusWidth (64),
            .ExtBusWidth (EW)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .mem_avail (mem_avail),
            .mem_addr  (mem_addr),
            .mem_busy  (mem_busy),
            .mem_done  (mem_done),
            .mem_data  (mem_data),
            .ext_req   (ext_req),
            .ext_addr  (ext_addr),
            .ext_gnt   (ext_gnt),
            .ext_rvalid(ext_rvalid),
            .ext_rdata (ext_rdata)
        );

        int          e0     = -10;
        int          done_c = -1;
        int          gd [4];
        int          rd [4];
        logic [31:0] addr_l [4];
        logic [63:0] cur_line = '0;
        logic [63:0] held     = '0;
        int          rb = 0, gcnt = 0, rcnt = 0;
        bit          rmode = 0, rst_chk = 0, started = 0, stray = 0;
        logic [63:0] exp_line [$];
        int          exp_done [$];

        // Reference model and external-bus responder.
        always @(negedge clk) begin
            bit            busy_exp;
            int            sum;
            logic [63:0]   ln;
            logic [31:0]   base;
            logic [EW-1:0] w;
            ext_gnt    = 1'b0;
            ext_rvalid = 1'b0;
            busy_exp   = (cyc > e0) && (cyc <= done_c);
            if (rst_chk) begin
                chk(g, "rst_busy", 64'(mem_busy), 64'd0);
                chk(g, "rst_done", 64'(mem_done), 64'd0);
                chk(g, "rst_req", 64'(ext_req), 64'd0);
                chk(g, "rst_ext_addr", 64'(ext_addr), 64'd0);
                chk(g, "rst_data", mem_data, 64'd0);
                rst_chk = 0;
            end else if (started) begin
                chk(g, "busy", 64'(mem_busy), 64'(busy_exp));
                if (!busy_exp) chk(g, "data_held", mem_data, held);
                if (busy_exp && rb < BEATS) begin
                    if (!rmode) begin
                        chk(g, "ext_req", 64'(ext_req), 64'd1);
                        chk(g, "ext_addr", 64'(ext_addr), 64'(addr_l[rb]));
                        if (gcnt == gd[rb]) begin
                            ext_gnt = 1'b1;
                            rmode   = 1;
                            rcnt    = 0;
                        end else begin
                            gcnt++;
                        end
                    end else begin
                        chk(g, "req_in_wait", 64'(ext_req), 64'd0);
                        if (rcnt == rd[rb]) begin
                            for (int k = 0; k < BB; k++) w[8*k +: 8] = mem_byte(addr_l[rb] + 32'(k));
                            ext_rdata  = w;
                            ext_rvalid = 1'b1;
                            rb++;
                            rmode = 0;
                            gcnt  = 0;
                        end else begin
                            rcnt++;
                        end
                    end
                end else begin
                    chk(g, "ext_req_off", 64'(ext_req), 64'd0);
                end
                if (cyc == done_c) held = cur_line;
                if (cyc == done_c + 1) chk(g, "done_missing", 64'(exp_done.size()), 64'd0);
            end
            if (stray) begin
                ext_rvalid = 1'b1;
                ext_rdata  = '1;
                stray      = 0;
            end
            if (rst) begin
                if (busy_exp) stray = 1;
                rst_chk = 1;
                started = 1;
                e0      = -10;
                done_c  = -1;
                rb      = 0;
                rmode   = 0;
                gcnt    = 0;
                held    = '0;
                exp_line.delete();
                exp_done.delete();
            end else if (started && mem_avail && cyc > done_c) begin
                e0   = cyc;
                sum  = 0;
                base = mem_addr & ~32'd7;
                for (int b = 0; b < BEATS; b++) begin
                    gd[b] = stall_en ? int'($urandom_range(0, 3)) : dir_gd[b];
                    rd[b] = stall_en ? int'($urandom_range(0, 3)) : dir_rd[b];
                    sum += gd[b] + rd[b];
                    addr_l[b] = base + 32'(b * BB);
                end
                done_c = cyc + 2 * BEATS + 1 + sum;
                for (int i = 0; i < 8; i++) ln[8*i +: 8] = mem_byte(base + 32'(i));
                cur_line = ln;
                exp_line.push_back(ln);
                exp_done.push_back(done_c);
                rb    = 0;
                rmode = 0;
                gcnt  = 0;
            end
        end

        // Scoreboard monitor.
        always @(negedge clk) begin
            if (started && mem_done === 1'b1) begin
                chk(g, "done_expected", 64'(exp_done.size() != 0), 64'd1);
                if (exp_done.size() != 0) begin
                    chk(g, "line", mem_data, exp_line.pop_front());
                    chk(g, "done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic request(input logic [31:0] a);
        mem_avail = 1'b1;
        mem_addr  = a;
        step();
        mem_avail = 1'b0;
        mem_addr  = $urandom;
    endtask

    function automatic bit all_idle();
        return (cyc > u[0].done_c) && (cyc > u[1].done_c);
    endfunction

    task automatic wait_idle();
        int t = 0;
        while (!all_idle() && t < 300) begin
            step();
            t++;
        end
        tests++;
        if (t >= 300) begin
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles, expected idle", t);
        end
    endtask

    task automatic wait_cyc(input int target);
        int t = 0;
        while (cyc < target && t < 100) begin
            step();
            t++;
        end
        tests++;
        if (cyc != target) begin
            fails++;
            $display("FAIL wait_cyc: reached cycle %0d, expected %0d", cyc, target);
        end
    endtask

    initial begin
        rst        = 1'b1;
        mem_avail  = 1'b0;
        mem_addr   = '0;
        use_fixed  = 1;
        stall_en   = 0;
        fixed_base = 32'h0000_1000;
        fixed_line = 64'hBBBB_0002_AAAA_0001;
        dir_gd     = '{0, 0, 0, 0};
        dir_rd     = '{0, 0, 0, 0};
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        step();

        request(32'h0000_1004);
        wait_idle();

        dir_gd = '{3, 0, 0, 0};
        dir_rd = '{0, 2, 0, 0};
        request(32'h0000_1000);
        wait_idle();

        dir_gd = '{0, 0, 0, 0};
        dir_rd = '{0, 0, 0, 0};
        request(32'h0000_1010);
        step();
        request(32'h0000_2000);
        wait_cyc(u[0].done_c);
        request(32'h0000_2000);
        wait_idle();

        request(32'h0000_3008);
        wait_cyc(u[0].e0 + 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        step();
        request(32'h0000_3000);
        wait_idle();

        request(32'hFFFF_FFFC);
        wait_idle();

        stall_en  = 1;
        use_fixed = 0;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) step();
            request($urandom);
            for (int j = 0; j < 8; j++) begin
                if ($urandom_range(0, 3) == 0) request($urandom);
                else step();
            end
            wait_idle();
        end

        repeat (4) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_line_fetch.md
# mem_line_fetch

Memory-side bridge directly downstream of the instruction cache's miss interface. Accepts one line-fill request per miss (`mem_avail` + `mem_addr`), fetches the line from a narrower external read bus as consecutive single-word beats, and assembles them into one `MemBusWidth` line. It then returns the line with a one-cycle `mem_done` pulse, holding `mem_busy` high for the whole transaction.

## Interface
Parameters:
- `AddrBusWidth`, default 32: byte-address width on both sides.
- `MemBusWidth`, default 64: line width returned to the cache.
- `ExtBusWidth`, default 32: external read-bus width. `MemBusWidth` must be an integer multiple of it.
- Derived (local, not overridable): `Beats = MemBusWidth/ExtBusWidth` (≥1); `LineBytes = MemBusWidth/8`; `BeatBytes = ExtBusWidth/8`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mem_avail`  in  1  line request strobe from the cache (one-cycle pulse).
- `mem_addr`  in  AddrBusWidth  request byte address; valid only while `mem_avail` is high.
- `mem_busy`  out  1  transaction in progress.
- `mem_done`  out  1  one-cycle pulse: `mem_data` holds the requested line.
- `mem_data`  out  MemBusWidth  assembled line.
- `ext_req`  out  1  external read request, held until granted.
- `ext_addr`  out  AddrBusWidth  external beat byte address.
- `ext_gnt`  in  1  external bus accepts the request in this cycle.
- `ext_rvalid`  in  1  `ext_rdata` is valid in this cycle.
- `ext_rdata`  in  ExtBusWidth  beat read data.

## Operation
- States: IDLE, ISSUE, WAIT, DONE. The state register, beat counter, base address and line register are all registered.
- **IDLE:**
  - When `mem_avail` is high, latch `base = mem_addr` with the low `log2(LineBytes)` bits forced to 0, clear `beat`, and go to ISSUE.
  - `ext_rvalid` is ignored in IDLE.
- **ISSUE:**
  - Drive `ext_req=1` and `ext_addr = base + beat*BeatBytes`.
  - On `ext_gnt`, go to WAIT. Otherwise stay in ISSUE, holding `ext_addr` stable.
- **WAIT:**
  - `ext_req=0`.
  - On `ext_rvalid`, write `ext_rdata` into line slice `[beat*ExtBusWidth +: ExtBusWidth]`. Beat 0 fills the least-significant bits.
  - If `beat == Beats-1`, go to DONE. Otherwise increment `beat` and go to ISSUE.
- **DONE:**
  - `mem_done=1` for exactly this one cycle, then go to IDLE.
- Only one external request is outstanding at a time. `ext_rvalid` is sampled only in WAIT.
- `mem_avail` is sampled only in IDLE. Pulses in ISSUE, WAIT or DONE are ignored and not queued. This includes the strobe the cache re-asserts in the same cycle as `mem_done`.
- `mem_busy = (state != IDLE)`. It is decoded from the registered state, so it carries no combinational path from inputs.
- `mem_data` is driven from the line register:
  - It holds the last assembled line until the next transaction overwrites beat slices.
  - It is only guaranteed complete while `mem_done` is high.
- Misaligned `mem_addr` is legal; the fetched line is always the aligned line containing it.
- Address arithmetic wraps modulo 2^AddrBusWidth. It cannot carry out of the aligned line.

## Timing
- Reset values:
  - state IDLE, `beat` 0, base 0, line register 0.
  - Outputs: `mem_busy=0`, `mem_done=0`, `mem_data=0`, `ext_req=0`, `ext_addr=0`.
- Reset mid-transaction:
  - Return to IDLE on the next edge and drop `ext_req`. No `mem_done` is produced.
  - A late `ext_rvalid` arriving after reset is ignored.
- Acceptance edge E0 is the edge where `mem_avail` is high in IDLE. `mem_busy` is high from the cycle after E0 through the DONE cycle inclusive, and low in the cycle after DONE.
- Minimum latency, with `ext_gnt` high in the first ISSUE cycle and `ext_rvalid` in the first WAIT cycle of each beat:
  - `mem_done` is high in cycle `2*Beats+1` after E0.
  - For the default parameters this is cycle 5.
  - Each stall cycle of `ext_gnt` or `ext_rvalid` adds exactly one cycle.
- Back-to-back: a new `mem_avail` is accepted in the first IDLE cycle after DONE, i.e. at the earliest 1 cycle after `mem_done`.
- `ext_gnt` and `ext_rvalid` for the same beat must not occur in the same cycle. `ext_rvalid` arrives at least one cycle after the grant.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs 0. Then `mem_avail`=1, `mem_addr`=0x0000_1004 → `ext_addr`=0x1000 then 0x1004. Return 0xAAAA_0001 then 0xBBBB_0002 → `mem_data`=0xBBBB_0002_AAAA_0001 with `mem_done` high in cycle 5 after E0, `mem_busy` high in cycles 1–5.
- **Stalls:** `ext_gnt` delayed 3 cycles on beat 0 and `ext_rvalid` delayed 2 cycles on beat 1 → `ext_req` and `ext_addr` stay stable while ungranted; `mem_done` in cycle 10; data correct.
- **Ignored strobes:** pulse `mem_avail` (addr 0x2000) in the DONE cycle and mid-WAIT → no second transaction, `ext_req` stays 0 after DONE, `mem_data` unchanged.
- **Reset mid-op:** assert `rst` in WAIT of beat 1, then drive `ext_rvalid` → no `mem_done`, `mem_busy`=0 next cycle; the following request completes normally.
- **Wrap-around:** `mem_addr`=0xFFFF_FFFC → `ext_addr`=0xFFFF_FFF8 then 0xFFFF_FFFC.
- **Parameter variant:** `ExtBusWidth`=16 → 4 beats at base+0, +2, +4, +6; `mem_done` in cycle 9; beat 0 occupies `mem_data[15:0]`.
